// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: fetch-response and decode handshakes around the prefetch buffer
interface fetch_buffer_if #(parameter int PTR_W = 2);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       in_instr_i;
  logic [31:0]       in_pc_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_instr_o;
  logic [31:0]       out_pc_o;
  logic              out_illegal_o;
  logic [PTR_W:0]    count_o;
  modport slave (
    input  flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_illegal_o, count_o
  );
  modport master (
    output flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_illegal_o, count_o
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: {pc, instr} prefetch FIFO feeding decode, flushed on redirect
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk_i,
  input  logic           reset_i,
  fetch_buffer_if.slave  bus
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             in_ready, out_valid, push, pop;
  logic [63:0]      head;
  assign in_ready  = count_q != FULL;
  assign out_valid = count_q != '0;
  assign push      = bus.in_valid_i & in_ready & ~bus.flush_i;
  assign pop       = out_valid & bus.out_ready_i & ~bus.flush_i;
  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    rd_d    = bus.flush_i ? '0 : rd_q + PTR_W'(pop);
    wr_d    = bus.flush_i ? '0 : wr_q + PTR_W'(push);
    count_d = bus.flush_i ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {bus.in_pc_i, bus.in_instr_i};
  end
  // Storage is unreset, so head fields are forced to zero while empty
  assign head              = mem_q[rd_q];
  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = out_valid;
  assign bus.out_instr_o   = out_valid ? head[31:0] : '0;
  assign bus.out_pc_o      = out_valid ? head[63:32] : '0;
  assign bus.out_illegal_o = out_valid & (head[1:0] != 2'b11);
  assign bus.count_o       = count_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed stimulus with an occupancy model and a decoupled head-data scoreboard
module tb_fetch_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int mcount = 0;
  logic [63:0] q[$];
  fetch_buffer_if #(.PTR_W(2)) bus();
  fetch_buffer #(.DEPTH(4), .PTR_W(2)) dut (.clk_i(clk), .reset_i(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  // Monitor: every consumed head must match the oldest accepted word
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o && bus.out_ready_i && !bus.flush_i) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop got=%0h/%0h want=none", bus.out_pc_o, bus.out_instr_o);
      end else begin
        logic [63:0] e;
        e = q.pop_front();
        chk("pop_pc", {32'h0, bus.out_pc_o}, {32'h0, e[63:32]});
        chk("pop_instr", {32'h0, bus.out_instr_o}, {32'h0, e[31:0]});
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    logic acc, pop;
    bus.in_valid_i  = v;
    bus.in_instr_i  = ins;
    bus.in_pc_i     = pc;
    bus.out_ready_i = rdy;
    bus.flush_i     = fl;
    #2;
    chk("count", {61'h0, bus.count_o}, 64'(mcount));
    chk("in_ready", {63'h0, bus.in_ready_o}, {63'h0, mcount != 4});
    chk("out_valid", {63'h0, bus.out_valid_o}, {63'h0, mcount != 0});
    if (mcount == 0) begin
      chk("empty_instr", {32'h0, bus.out_instr_o}, 64'h0);
      chk("empty_illegal", {63'h0, bus.out_illegal_o}, 64'h0);
    end else if (q.size() != 0) begin
      logic [63:0] h;
      h = q[0];
      chk("head_illegal", {63'h0, bus.out_illegal_o}, {63'h0, h[1:0] != 2'b11});
    end
    acc = v && mcount < 4 && !fl;
    pop = rdy && mcount != 0 && !fl;
    @(negedge clk);
    #1;
    if (fl) begin
      q.delete();
      mcount = 0;
    end else begin
      if (acc) q.push_back({pc, ins});
      mcount = mcount + int'(acc) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_instr_i  = '0;
    bus.in_pc_i     = '0;
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // 1: idle after reset
    idle(2, 1'b0);
    // 2: two pushes held, then popped in order
    step(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h00A00113, 32'h4, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    // 3: fill, push while full is ignored, one pop frees a slot
    for (int i = 0; i < 4; i++) step(1'b1, 32'h13 | (i << 20), 32'h100 + 4 * i, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD0013, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'hBEEF0013, 32'h204, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(4, 1'b1);
    // 4: steady push+pop at count 2 across pointer wraps
    step(1'b1, 32'h00000013, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00100013, 32'h304, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) step(1'b1, 32'h13 | (i << 20), 32'h300 + 4 * i, 1'b1, 1'b0);
    idle(3, 1'b1);
    // 5: flush at count 3 drops the same-cycle push
    for (int i = 0; i < 3; i++) step(1'b1, 32'h00000093 | (i << 20), 32'h400 + 4 * i, 1'b0, 1'b0);
    step(1'b1, 32'h0FF00093, 32'h40C, 1'b1, 1'b1);
    idle(3, 1'b1);
    // 6: illegal flag, then async reset mid-stream
    step(1'b1, 32'h00000001, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'h504, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00000002, 32'h508, 1'b0, 1'b0);
    step(1'b1, 32'h00000033, 32'h50C, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_count", {61'h0, bus.count_o}, 64'h0);
    chk("rst_out_valid", {63'h0, bus.out_valid_o}, 64'h0);
    chk("rst_in_ready", {63'h0, bus.in_ready_o}, 64'h1);
    q.delete();
    mcount = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 1'b1);
    step(1'b1, 32'h00700093, 32'h600, 1'b0, 1'b0);
    idle(2, 1'b1);
    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
